// File: rtl/brg_vvadd_xcel_network_rx.sv
// Slave-side network interface of the VVADD accelerator.
// Decodes endpoint loads/stores into a small CSR file and returns one response per request.
// It also sequences the accelerator core IDLE -> BUSY -> IDLE.
// Optional macro BRG_VVADD_XCEL_RX_PERF_EN adds a busy-cycle counter at CSR index 7.
module brg_vvadd_xcel_network_rx #(
  parameter int unsigned data_width_p   = 32,
  parameter int unsigned addr_width_p   = 28,
  parameter int unsigned x_cord_width_p = 4,
  parameter int unsigned y_cord_width_p = 5
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        in_v_i,
  input  logic [data_width_p-1:0]     in_data_i,
  input  logic [data_width_p/8-1:0]   in_mask_i,
  input  logic [addr_width_p-1:0]     in_addr_i,
  input  logic                        in_we_i,
  input  logic [x_cord_width_p-1:0]   in_src_x_cord_i,
  input  logic [y_cord_width_p-1:0]   in_src_y_cord_i,
  output logic                        in_yumi_o,
  output logic                        returning_v_o,
  output logic [data_width_p-1:0]     returning_data_o,
  output logic                        xcel_start_o,
  input  logic                        xcel_done_i,
  output logic [addr_width_p-1:0]     cfg_a_addr_o,
  output logic [addr_width_p-1:0]     cfg_b_addr_o,
  output logic [addr_width_p-1:0]     cfg_c_addr_o,
  output logic [data_width_p-1:0]     cfg_len_o,
  output logic [addr_width_p-1:0]     cfg_signal_addr_o
);

  localparam int unsigned IDX_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e                    r_state;
  state_e                    w_state_nxt;

  logic [addr_width_p-1:0]   r_a_addr;
  logic [addr_width_p-1:0]   r_b_addr;
  logic [addr_width_p-1:0]   r_c_addr;
  logic [data_width_p-1:0]   r_len;
  logic [addr_width_p-1:0]   r_sig_addr;
  logic                      r_err;
  logic [data_width_p-1:0]   r_done_cnt;
  logic                      r_ret_v;
  logic [data_width_p-1:0]   r_ret_data;
  logic                      r_start;

  logic [addr_width_p-1:0]   w_a_addr_nxt;
  logic [addr_width_p-1:0]   w_b_addr_nxt;
  logic [addr_width_p-1:0]   w_c_addr_nxt;
  logic [data_width_p-1:0]   w_len_nxt;
  logic [addr_width_p-1:0]   w_sig_addr_nxt;
  logic                      w_err_nxt;
  logic [data_width_p-1:0]   w_done_cnt_nxt;
  logic [data_width_p-1:0]   w_ret_data_nxt;
  logic                      w_start_nxt;
  logic                      w_go;

`ifdef BRG_VVADD_XCEL_RX_PERF_EN
  logic [data_width_p-1:0]   r_busy_cycles;
  logic [data_width_p-1:0]   w_busy_cycles_nxt;
`endif

  logic [IDX_W-1:0]          w_idx;
  logic                      w_oor;
  logic                      w_busy;
  logic                      w_full_mask;
  logic                      w_unused_ok;

  assign w_idx       = in_addr_i[IDX_W-1:0];
  assign w_oor       = |in_addr_i[addr_width_p-1:IDX_W];
  assign w_busy      = (r_state == ST_BUSY);
  assign w_full_mask = &in_mask_i;
  // Requester coordinates are carried for tracing only.
  assign w_unused_ok = ^{in_src_x_cord_i, in_src_y_cord_i};

  // No backpressure: every valid request is consumed; held low while in reset.
  assign in_yumi_o         = in_v_i & reset_n_i;
  assign returning_v_o     = r_ret_v;
  assign returning_data_o  = r_ret_data;
  assign xcel_start_o      = r_start;
  assign cfg_a_addr_o      = r_a_addr;
  assign cfg_b_addr_o      = r_b_addr;
  assign cfg_c_addr_o      = r_c_addr;
  assign cfg_len_o         = r_len;
  assign cfg_signal_addr_o = r_sig_addr;

  // FSM state register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, CSR update and response decode; all decisions use pre-update state.
  always_comb begin
    w_state_nxt    = r_state;
    w_a_addr_nxt   = r_a_addr;
    w_b_addr_nxt   = r_b_addr;
    w_c_addr_nxt   = r_c_addr;
    w_len_nxt      = r_len;
    w_sig_addr_nxt = r_sig_addr;
    w_err_nxt      = r_err;
    w_done_cnt_nxt = r_done_cnt;
    w_ret_data_nxt = '0;
    w_start_nxt    = 1'b0;
    w_go           = 1'b0;
`ifdef BRG_VVADD_XCEL_RX_PERF_EN
    w_busy_cycles_nxt = w_busy ? (r_busy_cycles + data_width_p'(1)) : r_busy_cycles;
`endif

    if (in_v_i && !in_we_i) begin
      // Loads: out-of-range addresses read as zero.
      if (!w_oor) begin
        unique case (w_idx)
          3'd0:    w_ret_data_nxt = data_width_p'(r_a_addr);
          3'd1:    w_ret_data_nxt = data_width_p'(r_b_addr);
          3'd2:    w_ret_data_nxt = data_width_p'(r_c_addr);
          3'd3:    w_ret_data_nxt = r_len;
          3'd4:    w_ret_data_nxt = data_width_p'(r_sig_addr);
          3'd5:    w_ret_data_nxt = data_width_p'({r_err, w_busy});
          3'd6:    w_ret_data_nxt = r_done_cnt;
          default: begin
`ifdef BRG_VVADD_XCEL_RX_PERF_EN
            w_ret_data_nxt = r_busy_cycles;
`else
            w_ret_data_nxt = '0;
`endif
          end
        endcase
      end
    end else if (in_v_i && in_we_i) begin
      // Stores: config CSRs are only writable when idle with a full mask.
      if (w_oor) begin
        w_err_nxt = 1'b1;
      end else begin
        unique case (w_idx)
          3'd0, 3'd1, 3'd2, 3'd3, 3'd4: begin
            if (!w_busy && w_full_mask) begin
              unique case (w_idx)
                3'd0:    w_a_addr_nxt   = in_data_i[addr_width_p-1:0];
                3'd1:    w_b_addr_nxt   = in_data_i[addr_width_p-1:0];
                3'd2:    w_c_addr_nxt   = in_data_i[addr_width_p-1:0];
                3'd3:    w_len_nxt      = in_data_i;
                default: w_sig_addr_nxt = in_data_i[addr_width_p-1:0];
              endcase
            end else begin
              w_err_nxt = 1'b1;
            end
          end
          3'd5: begin
            if (in_data_i[1]) begin
              w_err_nxt = 1'b0;
            end
            if (in_data_i[0]) begin
              if (w_busy) begin
                w_err_nxt = 1'b1;
              end else begin
                w_go = 1'b1;
              end
            end
          end
          3'd6: w_done_cnt_nxt = '0;
          default: begin
`ifdef BRG_VVADD_XCEL_RX_PERF_EN
            w_busy_cycles_nxt = '0;
`else
            w_err_nxt = 1'b1;
`endif
          end
        endcase
      end
    end

    // A go with zero length completes immediately without waking the core.
    if (w_go) begin
`ifdef BRG_VVADD_XCEL_RX_PERF_EN
      w_busy_cycles_nxt = '0;
`endif
      if (r_len != '0) begin
        w_start_nxt = 1'b1;
        w_state_nxt = ST_BUSY;
      end else begin
        w_done_cnt_nxt = w_done_cnt_nxt + data_width_p'(1);
      end
    end

    // Core completion; a stray done while idle is flagged.
    if (xcel_done_i) begin
      if (w_busy) begin
        w_state_nxt    = ST_IDLE;
        w_done_cnt_nxt = w_done_cnt_nxt + data_width_p'(1);
      end else begin
        w_err_nxt = 1'b1;
      end
    end
  end

  // CSR file, counters and registered response/start outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_a_addr   <= '0;
      r_b_addr   <= '0;
      r_c_addr   <= '0;
      r_len      <= '0;
      r_sig_addr <= '0;
      r_err      <= 1'b0;
      r_done_cnt <= '0;
      r_ret_v    <= 1'b0;
      r_ret_data <= '0;
      r_start    <= 1'b0;
    end else begin
      r_a_addr   <= w_a_addr_nxt;
      r_b_addr   <= w_b_addr_nxt;
      r_c_addr   <= w_c_addr_nxt;
      r_len      <= w_len_nxt;
      r_sig_addr <= w_sig_addr_nxt;
      r_err      <= w_err_nxt;
      r_done_cnt <= w_done_cnt_nxt;
      r_ret_v    <= in_v_i;
      r_ret_data <= w_ret_data_nxt;
      r_start    <= w_start_nxt;
    end
  end

`ifdef BRG_VVADD_XCEL_RX_PERF_EN
  // Busy-cycle performance counter.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_busy_cycles <= '0;
    end else begin
      r_busy_cycles <= w_busy_cycles_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_brg_vvadd_xcel_network_rx.sv
// Self-checking bench for brg_vvadd_xcel_network_rx: directed scenarios plus random traffic
// compared against a behavioural CSR/sequencer model.
module tb_brg_vvadd_xcel_network_rx;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        in_v_i;
  logic [31:0] in_data_i;
  logic [3:0]  in_mask_i;
  logic [27:0] in_addr_i;
  logic        in_we_i;
  logic [3:0]  in_src_x_cord_i;
  logic [4:0]  in_src_y_cord_i;
  logic        in_yumi_o;
  logic        returning_v_o;
  logic [31:0] returning_data_o;
  logic        xcel_start_o;
  logic        xcel_done_i;
  logic [27:0] cfg_a_addr_o;
  logic [27:0] cfg_b_addr_o;
  logic [27:0] cfg_c_addr_o;
  logic [31:0] cfg_len_o;
  logic [27:0] cfg_signal_addr_o;

  brg_vvadd_xcel_network_rx dut (
    .clk_i            (clk_i),
    .reset_n_i        (reset_n_i),
    .in_v_i           (in_v_i),
    .in_data_i        (in_data_i),
    .in_mask_i        (in_mask_i),
    .in_addr_i        (in_addr_i),
    .in_we_i          (in_we_i),
    .in_src_x_cord_i  (in_src_x_cord_i),
    .in_src_y_cord_i  (in_src_y_cord_i),
    .in_yumi_o        (in_yumi_o),
    .returning_v_o    (returning_v_o),
    .returning_data_o (returning_data_o),
    .xcel_start_o     (xcel_start_o),
    .xcel_done_i      (xcel_done_i),
    .cfg_a_addr_o     (cfg_a_addr_o),
    .cfg_b_addr_o     (cfg_b_addr_o),
    .cfg_c_addr_o     (cfg_c_addr_o),
    .cfg_len_o        (cfg_len_o),
    .cfg_signal_addr_o(cfg_signal_addr_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state.
  logic [31:0] m_csr [5];
  logic        m_err;
  logic        m_busy;
  logic [31:0] m_done;
  logic [31:0] m_perf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_csr[i] = '0;
    m_err  = 1'b0;
    m_busy = 1'b0;
    m_done = '0;
    m_perf = '0;
  endtask

  task automatic check_cfg();
    check("cfg_a",   32'(cfg_a_addr_o),      m_csr[0]);
    check("cfg_b",   32'(cfg_b_addr_o),      m_csr[1]);
    check("cfg_c",   32'(cfg_c_addr_o),      m_csr[2]);
    check("cfg_len", cfg_len_o,              m_csr[3]);
    check("cfg_sig", 32'(cfg_signal_addr_o), m_csr[4]);
  endtask

  // One clock cycle: drive a request and/or done pulse, predict, then check outputs.
  task automatic step(input logic v, input logic we, input logic [27:0] addr,
                      input logic [31:0] data, input logic [3:0] mask, input logic done);
    logic [31:0] exp_rd;
    logic        exp_start;
    logic        pre_busy;
    logic        oor;
    int          idx;
    in_v_i          = v;
    in_we_i         = we;
    in_addr_i       = addr;
    in_data_i       = data;
    in_mask_i       = mask;
    xcel_done_i     = done;
    in_src_x_cord_i = 4'($urandom);
    in_src_y_cord_i = 5'($urandom);
    #1;
    check("yumi", 32'(in_yumi_o), 32'(v));

    pre_busy  = m_busy;
    idx       = int'(addr[2:0]);
    oor       = (addr[27:3] != '0);
    exp_rd    = '0;
    exp_start = 1'b0;

    if (v && !we && !oor) begin
      if (idx < 5)       exp_rd = m_csr[idx];
      else if (idx == 5) exp_rd = {30'd0, m_err, pre_busy};
      else if (idx == 6) exp_rd = m_done;
      else begin
`ifdef BRG_VVADD_XCEL_RX_PERF_EN
        exp_rd = m_perf;
`endif
      end
    end

    if (pre_busy) m_perf = m_perf + 32'd1;

    if (v && we) begin
      if (oor) m_err = 1'b1;
      else if (idx < 5) begin
        if (!pre_busy && mask == 4'hF) m_csr[idx] = (idx == 3) ? data : (data & 32'h0FFF_FFFF);
        else m_err = 1'b1;
      end else if (idx == 5) begin
        if (data[1]) m_err = 1'b0;
        if (data[0]) begin
          if (pre_busy) m_err = 1'b1;
          else begin
            m_perf = '0;
            if (m_csr[3] != 0) begin
              m_busy    = 1'b1;
              exp_start = 1'b1;
            end else begin
              m_done = m_done + 32'd1;
            end
          end
        end
      end else if (idx == 6) m_done = '0;
      else begin
`ifdef BRG_VVADD_XCEL_RX_PERF_EN
        m_perf = '0;
`else
        m_err = 1'b1;
`endif
      end
    end

    if (done) begin
      if (pre_busy) begin
        m_busy = 1'b0;
        m_done = m_done + 32'd1;
      end else begin
        m_err = 1'b1;
      end
    end

    @(posedge clk_i);
    #1;
    check("ret_v", 32'(returning_v_o), 32'(v));
    if (v) check("ret_data", returning_data_o, exp_rd);
    check("start", 32'(xcel_start_o), 32'(exp_start));
    check_cfg();
  endtask

  task automatic wr(input int idx, input logic [31:0] data);
    step(1'b1, 1'b1, 28'(idx), data, 4'hF, 1'b0);
  endtask

  task automatic rd(input int idx);
    step(1'b1, 1'b0, 28'(idx), 32'h0, 4'hF, 1'b0);
  endtask

  task automatic idle(input logic done);
    step(1'b0, 1'b0, 28'h0, 32'h0, 4'h0, done);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_yumi"},  32'(in_yumi_o),        32'd0);
    check({tag, "_ret_v"}, 32'(returning_v_o),    32'd0);
    check({tag, "_ret_d"}, returning_data_o,      32'd0);
    check({tag, "_start"}, 32'(xcel_start_o),     32'd0);
    check({tag, "_a"},     32'(cfg_a_addr_o),     32'd0);
    check({tag, "_b"},     32'(cfg_b_addr_o),     32'd0);
    check({tag, "_c"},     32'(cfg_c_addr_o),     32'd0);
    check({tag, "_len"},   cfg_len_o,             32'd0);
    check({tag, "_sig"},   32'(cfg_signal_addr_o), 32'd0);
  endtask

  initial begin
    logic        r_v;
    logic        r_we;
    logic        r_done;
    logic [27:0] r_addr;
    logic [31:0] r_data;
    logic [3:0]  r_mask;
    int          r_idx;

    reset_n_i       = 1'b0;
    in_v_i          = 1'b1;
    in_we_i         = 1'b0;
    in_addr_i       = '0;
    in_data_i       = '0;
    in_mask_i       = '0;
    in_src_x_cord_i = '0;
    in_src_y_cord_i = '0;
    xcel_done_i     = 1'b0;
    model_reset();
    #12;
    check_all_zero("rst");
    in_v_i    = 1'b0;
    reset_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    // CSR write and read-back.
    wr(0, 32'h100); wr(1, 32'h200); wr(2, 32'h300); wr(3, 32'd4);
    rd(0); rd(1); rd(2); rd(3); rd(5);

    // Go, run, done.
    wr(5, 32'h1); rd(5); idle(1'b0); idle(1'b1); rd(5); rd(6);

    // Writes while busy are dropped and flagged.
    wr(5, 32'h1); wr(0, 32'hABC); wr(5, 32'h1); rd(5); rd(0);
    wr(5, 32'h2); rd(5); idle(1'b1); rd(0); rd(5);

    // Partial mask store.
    step(1'b1, 1'b1, 28'd1, 32'hDEAD, 4'b0011, 1'b0); rd(1); rd(5); wr(5, 32'h2);

    // Zero-length go and back-to-back loads.
    wr(3, 32'd0); wr(6, 32'd0); wr(5, 32'h1); rd(6);
    for (int i = 0; i < 8; i++) rd(i);

    // Unmapped accesses and stray done.
    step(1'b1, 1'b0, 28'h8, 32'h0, 4'hF, 1'b0);
    wr(5, 32'h2); step(1'b1, 1'b1, 28'h10, 32'h5, 4'hF, 1'b0); rd(5);
    wr(5, 32'h2); wr(7, 32'h1); rd(5);
    wr(5, 32'h2); idle(1'b1); rd(5); wr(5, 32'h2);

`ifdef BRG_VVADD_XCEL_RX_PERF_EN
    wr(3, 32'd4); wr(5, 32'h1);
    for (int i = 0; i < 9; i++) idle(1'b0);
    rd(7); idle(1'b1); rd(7);
`endif

    // Reset while busy with a response pending.
    wr(3, 32'd5); wr(0, 32'h55); wr(5, 32'h1); idle(1'b0);
    in_v_i    = 1'b1;
    in_we_i   = 1'b0;
    in_addr_i = 28'd5;
    @(posedge clk_i);
    #3;
    reset_n_i = 1'b0;
    #1;
    check_all_zero("midrst");
    in_v_i = 1'b0;
    #1;
    reset_n_i = 1'b1;
    model_reset();
    @(posedge clk_i);
    #1;
    rd(5); rd(0); rd(3);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      r_v   = ($urandom_range(0, 3) != 0);
      r_we  = $urandom_range(0, 1) == 1;
      r_idx = $urandom_range(0, 7);
      r_addr = 28'(r_idx);
      if ($urandom_range(0, 15) == 0) r_addr = r_addr | (28'd1 << $urandom_range(3, 27));
      r_mask = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
      if (r_idx == 3)      r_data = 32'($urandom_range(0, 3));
      else if (r_idx == 5) r_data = 32'($urandom_range(0, 3));
      else                 r_data = $urandom;
      if (m_busy) r_done = ($urandom_range(0, 7) == 0);
      else        r_done = ($urandom_range(0, 39) == 0);
      step(r_v, r_we, r_addr, r_data, r_mask, r_done);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
